// File: rtl/pipe_dut.sv
// rtl/pipe_dut.sv - DEPTH-stage valid/ready pipeline with bubble collapse
// Optional beat statistics counters are enabled by defining PIPE_DUT_STATS_EN.
module pipe_dut #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  rx_en,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_rdy,
  output logic                  tx_en,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_rdy,
  output logic [CNT_W-1:0]      occupancy
`ifdef PIPE_DUT_STATS_EN
  ,
  output logic [15:0]           stat_in,
  output logic [15:0]           stat_out,
  output logic [15:0]           stat_drop
`endif
);

  logic [DEPTH-1:0]      r_v;
  logic [DATA_WIDTH-1:0] r_d [DEPTH];
  logic [CNT_W-1:0]      r_occ;
  logic [DEPTH-1:0]      w_adv;
  logic                  w_rx_rdy;
  logic                  w_in;
  logic                  w_out;

  // A stage may load when it is empty or when the stage after it is moving.
  always_comb begin : adv_chain
    logic acc;
    acc   = tx_rdy;
    w_adv = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc      = !r_v[i] || acc;
      w_adv[i] = acc;
    end
  end

  assign w_rx_rdy  = w_adv[0] && !flush;
  assign w_in      = rx_en && w_rx_rdy;
  assign w_out     = r_v[DEPTH-1] && tx_rdy;

  assign rx_rdy    = w_rx_rdy;
  assign tx_en     = r_v[DEPTH-1];
  assign tx_data   = r_d[DEPTH-1];
  assign occupancy = r_occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int i = 0; i < DEPTH; i++) r_d[i] <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_adv[0]) begin
        r_v[0] <= rx_en;
        r_d[0] <= rx_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (w_adv[i]) begin
          r_v[i] <= r_v[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     r_occ <= '0;
    else if (flush) r_occ <= '0;
    else            r_occ <= r_occ + CNT_W'(w_in) - CNT_W'(w_out);
  end

`ifdef PIPE_DUT_STATS_EN
  logic [15:0]      r_stat_in;
  logic [15:0]      r_stat_out;
  logic [15:0]      r_stat_drop;
  logic [CNT_W-1:0] w_drop_amt;
  logic [16:0]      w_drop_sum;

  // A beat delivered in the flush cycle is not counted as dropped.
  assign w_drop_amt = r_occ - CNT_W'(w_out);
  assign w_drop_sum = {1'b0, r_stat_drop} + 17'(w_drop_amt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_in   <= '0;
      r_stat_out  <= '0;
      r_stat_drop <= '0;
    end else begin
      if (w_in && r_stat_in != 16'hFFFF)   r_stat_in  <= r_stat_in + 16'd1;
      if (w_out && r_stat_out != 16'hFFFF) r_stat_out <= r_stat_out + 16'd1;
      if (flush) r_stat_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign stat_in   = r_stat_in;
  assign stat_out  = r_stat_out;
  assign stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_pipe_dut.sv
// tb/tb_pipe_dut.sv - table-driven and scoreboard bench for pipe_dut (DEPTH=4)
module tb_pipe_dut;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_rdy;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_rdy = 1'b0;
  logic [2:0] occupancy;
`ifdef PIPE_DUT_STATS_EN
  logic [15:0] stat_in, stat_out, stat_drop;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  pipe_dut #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .rx_en(rx_en), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .tx_en(tx_en), .tx_data(tx_data), .tx_rdy(tx_rdy),
    .occupancy(occupancy)
`ifdef PIPE_DUT_STATS_EN
    , .stat_in(stat_in), .stat_out(stat_out), .stat_drop(stat_drop)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: beats pushed on accept, popped and compared on delivery.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("sb_occupancy", 32'(occupancy), 32'(sb.size()));
      if (!rst_n) begin
        sb.delete();
      end else begin
        if (tx_en && tx_rdy) begin
          if (sb.size() == 0) chk("sb_unexpected_beat", 32'(tx_data), 32'hFFFF_FFFF);
          else chk("sb_data", 32'(tx_data), 32'(sb.pop_front()));
        end
        if (flush) sb.delete();
        else if (rx_en && rx_rdy) sb.push_back(rx_data);
      end
    end
  end

  task automatic step(input logic en, input logic [7:0] d, input logic rdy,
                      input logic fl, input logic rst);
    @(posedge clk);
    #1;
    rx_en = en; rx_data = d; tx_rdy = rdy; flush = fl; rst_n = rst;
    @(negedge clk);
  endtask

  typedef struct {
    logic       en;
    logic [7:0] d;
    logic       rdy;
    logic       fl;
    logic       e_rdy;
    logic       e_tx;
    logic [7:0] e_data;
    logic [2:0] e_occ;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  initial begin
    // T1 latency
    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    vec[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    vec[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1};
    vec[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    // T3 backpressure fill
    vec[6]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
    vec[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
    vec[8]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2};
    vec[9]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3};
    vec[10] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 3'd4};
    vec[11] = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 3'd4};
    // T4 full pass-through
    vec[12] = '{1'b1, 8'h14, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 3'd4};
    vec[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4};
    vec[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4};
    // T5 flush with three beats held
    vec[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 3'd3};
    vec[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};

    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("reset_tx_en", 32'(tx_en), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);
    chk("reset_rx_rdy", 32'(rx_rdy), 32'd1);
    mon_en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vec[i].en, vec[i].d, vec[i].rdy, vec[i].fl, 1'b1);
      chk($sformatf("v%0d_rx_rdy", i), 32'(rx_rdy), 32'(vec[i].e_rdy));
      chk($sformatf("v%0d_tx_en", i), 32'(tx_en), 32'(vec[i].e_tx));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(vec[i].e_occ));
      if (vec[i].e_tx) chk($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vec[i].e_data));
    end
`ifdef PIPE_DUT_STATS_EN
    chk("stat_drop", 32'(stat_drop), 32'd3);
    chk("stat_in", 32'(stat_in), 32'd6);
    chk("stat_out", 32'(stat_out), 32'd3);
`endif

    // T2 streaming: 16 back-to-back beats, outputs on cycles 4..19
    for (int c = 0; c < 21; c++) begin
      step(c < 16, 8'(c), 1'b1, 1'b0, 1'b1);
      chk($sformatf("t2_c%0d_rx_rdy", c), 32'(rx_rdy), 32'd1);
      chk($sformatf("t2_c%0d_tx_en", c), 32'(tx_en), 32'(c >= 4 && c < 20));
      if (tx_en) chk($sformatf("t2_c%0d_tx_data", c), 32'(tx_data), 32'(c - 4));
    end

    // T6 reset mid-stream with two beats held
    step(1'b1, 8'h31, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h32, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6_occ_before_reset", 32'(occupancy), 32'd2);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t6_tx_en_after_reset", 32'(tx_en), 32'd0);
    chk("t6_tx_data_after_reset", 32'(tx_data), 32'd0);
    chk("t6_occ_after_reset", 32'(occupancy), 32'd0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      chk($sformatf("t6_k%0d_tx_en", k), 32'(tx_en), 32'(k == 4));
      if (k == 4) chk("t6_tx_data", 32'(tx_data), 32'h55);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("final_occ", 32'(occupancy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
